vmem_tlb_responder: RTL and testbench

Synthesizable paging-side responder for the CPU request/acknowledge protocol. It accepts CPU read/write requests carrying virtual addresses and translates them through a small fully-associative TLB. On a miss it walks a single-level page table through the L1 port, then issues the physical access to L1 and acknowledges the CPU. It sits between the CPU-side initiator and L1_Cache, on the same VMEM_Request/VMEM_ACK interface L1 already serves, and also executes the TLB-flush operation.

---
 rtl/vmem_tlb_responder_if.sv | 34 +++
 rtl/vmem_tlb_responder.sv | 210 +++++++++++++++++++++
 tb/tb_vmem_tlb_responder.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vmem_tlb_responder_if.sv
// CPU-side request/acknowledge bus and the L1 VMEM bus served by the TLB responder.
// The slave modport is the responder's view; the master modport is the
// surrounding environment (CPU initiator plus L1 cache).
interface vmem_tlb_responder_if;
  logic        CPU_Request;
  logic        CPU_WE;
  logic [31:0] CPU_Address;
  logic [31:0] CPU_WData;
  logic [31:0] CPU_RData;
  logic        CPU_ACK;
  logic        PageFault;
  logic        OP_Request;
  logic [3:0]  OPERATIONS;
  logic        VMEM_Request;
  logic        VMEM_WE;
  logic [31:0] VMEM_Address;
  logic [31:0] VMEM_WData;
  logic [31:0] VMEM_RData;
  logic        VMEM_ACK;

  modport slave (
    input  CPU_Request, CPU_WE, CPU_Address, CPU_WData, OP_Request, OPERATIONS,
           VMEM_RData, VMEM_ACK,
    output CPU_RData, CPU_ACK, PageFault, VMEM_Request, VMEM_WE, VMEM_Address,
           VMEM_WData
  );

  modport master (
    output CPU_Request, CPU_WE, CPU_Address, CPU_WData, OP_Request, OPERATIONS,
           VMEM_RData, VMEM_ACK,
    input  CPU_RData, CPU_ACK, PageFault, VMEM_Request, VMEM_WE, VMEM_Address,
           VMEM_WData
  );
endinterface

// File: rtl/vmem_tlb_responder.sv
// Paging responder: translates CPU virtual addresses through a small fully
// associative TLB, walks a single-level page table in L1 on a miss, performs
// the physical access and acknowledges the CPU. Also executes TLB flush.
module vmem_tlb_responder #(
  parameter int          ENTRIES   = 4,
  parameter int          PAGE_BITS = 12,
  parameter logic [31:0] PT_BASE   = 32'h0010_0000
) (
  input  logic                clk,
  input  logic                reset,
  vmem_tlb_responder_if.slave bus,
  output logic [15:0]         TLB_Hits,
  output logic [15:0]         TLB_Misses
);
  localparam int         VPN_W    = 32 - PAGE_BITS;
  localparam int         IDX_W    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [3:0] OP_FLUSH = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WALK_REQ, S_WALK_REL, S_ACC_REQ, S_ACC_REL, S_RESP, S_FLUSH
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t             r_state;
  logic [31:0]        r_va;
  logic               r_we;
  logic [31:0]        r_wdata;
  logic [31:0]        r_pa;
  logic [VPN_W-1:0]   r_pte_pfn;
  logic               r_pte_vld;
  logic [ENTRIES-1:0] r_vld;
  logic [VPN_W-1:0]   r_vpn [ENTRIES];
  logic [VPN_W-1:0]   r_pfn [ENTRIES];
  logic [IDX_W-1:0]   r_ptr;
  logic               r_cpu_ack;
  logic               r_fault;
  logic [31:0]        r_cpu_rdata;
  logic               r_vmem_req;
  logic               r_vmem_we;
  logic [31:0]        r_vmem_addr;
  logic [31:0]        r_vmem_wdata;
  logic [15:0]        r_hits;
  logic [15:0]        r_misses;

  logic [VPN_W-1:0]     w_vpn;
  logic [PAGE_BITS-1:0] w_off;
  logic [31:0]          w_pte_addr;
  logic                 w_hit;
  logic [VPN_W-1:0]     w_hit_pfn;
  logic                 w_free;
  logic [IDX_W-1:0]     w_free_idx;
  logic [IDX_W-1:0]     w_victim;
  logic                 w_flush_req;
  logic                 w_take;
  logic                 w_fill;

  assign w_vpn       = r_va[31:PAGE_BITS];
  assign w_off       = r_va[PAGE_BITS-1:0];
  assign w_pte_addr  = PT_BASE + {{(PAGE_BITS-2){1'b0}}, w_vpn, 2'b00};
  assign w_flush_req = bus.OP_Request && (bus.OPERATIONS == OP_FLUSH);
  // Flush has priority; the CPU request stays pending until the next IDLE cycle.
  assign w_take      = (r_state == S_IDLE) && !w_flush_req && bus.CPU_Request;
  assign w_fill      = (r_state == S_WALK_REL) && !bus.VMEM_ACK && r_pte_vld;
  assign w_victim    = w_free ? w_free_idx : r_ptr;

  assign bus.CPU_RData    = r_cpu_rdata;
  assign bus.CPU_ACK      = r_cpu_ack;
  assign bus.PageFault    = r_fault;
  assign bus.VMEM_Request = r_vmem_req;
  assign bus.VMEM_WE      = r_vmem_we;
  assign bus.VMEM_Address = r_vmem_addr;
  assign bus.VMEM_WData   = r_vmem_wdata;
  assign TLB_Hits         = r_hits;
  assign TLB_Misses       = r_misses;

  // Associative match of the latched VPN against every valid entry.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_pfn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_vld[i] && (r_vpn[i] == w_vpn) && !w_hit) begin
        w_hit     = 1'b1;
        w_hit_pfn = r_pfn[i];
      end
    end
  end

  // Lowest-index invalid entry is the preferred fill slot.
  always_comb begin
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_vld[i]) begin
        w_free     = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  // Datapath holding registers and TLB tag/PFN storage (validity lives in r_vld).
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_va    <= bus.CPU_Address;
      r_we    <= bus.CPU_WE;
      r_wdata <= bus.CPU_WData;
    end
    if (r_state == S_LOOKUP) begin
      r_pa <= {w_hit_pfn, w_off};
    end
    if ((r_state == S_WALK_REQ) && bus.VMEM_ACK) begin
      r_pte_pfn <= bus.VMEM_RData[31:PAGE_BITS];
      r_pte_vld <= bus.VMEM_RData[0];
    end
    if (w_fill) begin
      r_pa             <= {r_pte_pfn, w_off};
      r_vpn[w_victim]  <= w_vpn;
      r_pfn[w_victim]  <= r_pte_pfn;
    end
  end

  // Main FSM: lookup, page walk, physical access and CPU handshake, all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_vld        <= '0;
      r_ptr        <= '0;
      r_cpu_ack    <= 1'b0;
      r_fault      <= 1'b0;
      r_cpu_rdata  <= '0;
      r_vmem_req   <= 1'b0;
      r_vmem_we    <= 1'b0;
      r_vmem_addr  <= '0;
      r_vmem_wdata <= '0;
      r_hits       <= '0;
      r_misses     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_flush_req)          r_state <= S_FLUSH;
          else if (bus.CPU_Request) r_state <= S_LOOKUP;
        end
        S_FLUSH: begin
          r_vld   <= '0;
          r_state <= S_IDLE;
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_hits  <= sat_inc(r_hits);
            r_state <= S_ACC_REQ;
          end else begin
            r_misses <= sat_inc(r_misses);
            r_state  <= S_WALK_REQ;
          end
        end
        S_WALK_REQ: begin
          if (bus.VMEM_ACK) begin
            r_vmem_req <= 1'b0;
            r_state    <= S_WALK_REL;
          end else begin
            r_vmem_req  <= 1'b1;
            r_vmem_we   <= 1'b0;
            r_vmem_addr <= w_pte_addr;
          end
        end
        S_WALK_REL: begin
          if (!bus.VMEM_ACK) begin
            if (r_pte_vld) begin
              r_vld[w_victim] <= 1'b1;
              if (!w_free) begin
                r_ptr <= (r_ptr == IDX_W'(ENTRIES - 1)) ? '0 : r_ptr + 1'b1;
              end
              r_state <= S_ACC_REQ;
            end else begin
              r_fault <= 1'b1;
              r_state <= S_RESP;
            end
          end
        end
        S_ACC_REQ: begin
          if (bus.VMEM_ACK) begin
            r_vmem_req <= 1'b0;
            if (!r_we) r_cpu_rdata <= bus.VMEM_RData;
            r_state <= S_ACC_REL;
          end else begin
            r_vmem_req   <= 1'b1;
            r_vmem_we    <= r_we;
            r_vmem_addr  <= r_pa;
            r_vmem_wdata <= r_wdata;
          end
        end
        S_ACC_REL: begin
          if (!bus.VMEM_ACK) r_state <= S_RESP;
        end
        S_RESP: begin
          if (!r_cpu_ack) begin
            r_cpu_ack <= 1'b1;
          end else if (!bus.CPU_Request) begin
            r_cpu_ack <= 1'b0;
            r_fault   <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vmem_tlb_responder.sv
// Bench for vmem_tlb_responder: directed scenarios plus random traffic against
// a behavioural TLB/page-table model, with an L1 responder model and a
// scoreboard monitor on the CPU acknowledge.
module tb_vmem_tlb_responder;
  localparam int          ENT = 4;
  localparam logic [31:0] PTB = 32'h0010_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] hits;
  logic [15:0] misses;

  vmem_tlb_responder_if bus();

  vmem_tlb_responder #(.ENTRIES(ENT), .PAGE_BITS(12), .PT_BASE(PTB)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .TLB_Hits   (hits),
    .TLB_Misses (misses)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fault;
    logic        chk_rd;
    logic [31:0] rdata;
    logic [15:0] hits;
    logic [15:0] misses;
  } resp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } l1_t;

  resp_t       resp_q[$];
  l1_t         l1_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] mem [logic [31:0]];
  bit          l1_hold = 1'b0;

  // reference TLB
  bit          m_vld [ENT];
  logic [19:0] m_vpn [ENT];
  logic [19:0] m_pfn [ENT];
  int          m_ptr;
  int          m_hits;
  int          m_misses;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) m_vld[i] = 1'b0;
    m_ptr = 0;
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic model_flush();
    for (int i = 0; i < ENT; i++) m_vld[i] = 1'b0;
  endtask

  // Predict the full transaction: L1 traffic and the CPU-visible response.
  task automatic model_req(input logic [31:0] va, input logic we, input logic [31:0] wd,
                           output resp_t r);
    logic [19:0] vpn;
    logic [31:0] pa, pte, pte_a;
    int hit, victim;
    vpn = va[31:12];
    hit = -1;
    pa = '0;
    r = '0;
    r.chk_rd = !we;
    for (int i = 0; i < ENT; i++)
      if (m_vld[i] && m_vpn[i] == vpn && hit < 0) hit = i;
    if (hit >= 0) begin
      m_hits = sat(m_hits + 1);
      pa = {m_pfn[hit], va[11:0]};
    end else begin
      m_misses = sat(m_misses + 1);
      pte_a = PTB + {10'd0, vpn, 2'b00};
      pte = mem_rd(pte_a);
      l1_q.push_back('{1'b0, pte_a, 32'd0});
      if (!pte[0]) begin
        r.fault = 1'b1;
        r.chk_rd = 1'b0;
      end else begin
        victim = -1;
        for (int i = 0; i < ENT; i++)
          if (!m_vld[i] && victim < 0) victim = i;
        if (victim < 0) begin
          victim = m_ptr;
          m_ptr = (m_ptr + 1) % ENT;
        end
        m_vld[victim] = 1'b1;
        m_vpn[victim] = vpn;
        m_pfn[victim] = pte[31:12];
        pa = {pte[31:12], va[11:0]};
      end
    end
    if (!r.fault) begin
      l1_q.push_back('{we, pa, wd});
      if (we) mem[pa] = wd;
      else    r.rdata = mem_rd(pa);
    end
    r.hits = 16'(m_hits);
    r.misses = 16'(m_misses);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cpu_ack"},   32'(bus.CPU_ACK), 32'd0);
    chk({tag, "_pagefault"}, 32'(bus.PageFault), 32'd0);
    chk({tag, "_cpu_rdata"}, bus.CPU_RData, 32'd0);
    chk({tag, "_vmem_req"},  32'(bus.VMEM_Request), 32'd0);
    chk({tag, "_vmem_we"},   32'(bus.VMEM_WE), 32'd0);
    chk({tag, "_vmem_addr"}, bus.VMEM_Address, 32'd0);
    chk({tag, "_vmem_wdata"}, bus.VMEM_WData, 32'd0);
    chk({tag, "_hits"},      32'(hits), 32'd0);
    chk({tag, "_misses"},    32'(misses), 32'd0);
  endtask

  task automatic do_op(input logic [3:0] op);
    if (op == 4'b1000) model_flush();
    @(negedge clk);
    bus.OP_Request = 1'b1;
    bus.OPERATIONS = op;
    @(negedge clk);
    bus.OP_Request = 1'b0;
    @(negedge clk);
  endtask

  // One full CPU four-phase transaction; lat = negedges from request to first VMEM_Request.
  task automatic do_req(input logic [31:0] va, input logic we, input logic [31:0] wd,
                        input bit with_op, input logic [3:0] op, output int lat);
    resp_t r;
    int n;
    if (with_op && op == 4'b1000) model_flush();
    model_req(va, we, wd, r);
    resp_q.push_back(r);
    @(negedge clk);
    bus.CPU_Address = va;
    bus.CPU_WE = we;
    bus.CPU_WData = wd;
    bus.CPU_Request = 1'b1;
    bus.OP_Request = with_op;
    bus.OPERATIONS = op;
    lat = -1;
    n = 0;
    while (!bus.CPU_ACK && n < 200) begin
      @(negedge clk);
      bus.OP_Request = 1'b0;
      n++;
      if (lat < 0 && bus.VMEM_Request) lat = n;
    end
    chk("cpu_ack_rise", 32'(bus.CPU_ACK), 32'd1);
    bus.CPU_Request = 1'b0;
    @(negedge clk);
    chk("cpu_ack_fall", 32'(bus.CPU_ACK), 32'd0);
    chk("pagefault_clear", 32'(bus.PageFault), 32'd0);
  endtask

  // Scoreboard monitor: on every CPU_ACK rising, compare against the oldest prediction.
  initial begin
    logic  prev;
    resp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.CPU_ACK && !prev) begin
        if (resp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_cpu_ack: got ack with no outstanding request (t=%0t)", $time);
        end else begin
          e = resp_q.pop_front();
          chk("pagefault", 32'(bus.PageFault), 32'(e.fault));
          if (e.chk_rd) chk("cpu_rdata", bus.CPU_RData, e.rdata);
          chk("tlb_hits", 32'(hits), 32'(e.hits));
          chk("tlb_misses", 32'(misses), 32'(e.misses));
        end
      end
      prev = bus.CPU_ACK;
    end
  end

  // L1 model: four-phase slave with random latency, checks each request against the prediction.
  initial begin
    int  ph;
    int  dly;
    l1_t e;
    l1_t got;
    ph = 0;
    dly = 0;
    got = '0;
    bus.VMEM_ACK = 1'b0;
    bus.VMEM_RData = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        bus.VMEM_ACK = 1'b0;
        ph = 0;
      end else begin
        case (ph)
          0: if (bus.VMEM_Request) begin
               got = '{bus.VMEM_WE, bus.VMEM_Address, bus.VMEM_WData};
               if (l1_q.size() == 0) begin
                 total++;
                 bad++;
                 $display("FAIL unexpected_l1_req: addr %h we %0d with none expected", got.addr, got.we);
               end else begin
                 e = l1_q.pop_front();
                 chk("l1_we", 32'(got.we), 32'(e.we));
                 chk("l1_addr", got.addr, e.addr);
                 if (e.we) chk("l1_wdata", got.wdata, e.wdata);
               end
               dly = $urandom_range(0, 3);
               ph = 1;
             end
          1: if (!l1_hold) begin
               if (dly == 0) begin
                 bus.VMEM_RData = got.we ? $urandom : mem_rd(got.addr);
                 bus.VMEM_ACK = 1'b1;
                 ph = 2;
               end else begin
                 dly--;
               end
             end
          default: if (!bus.VMEM_Request) begin
               bus.VMEM_ACK = 1'b0;
               bus.VMEM_RData = $urandom;
               ph = 0;
             end
        endcase
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    resp_t dummy;
    logic [19:0] pfn;
    bus.CPU_Request = 1'b0;
    bus.CPU_WE = 1'b0;
    bus.CPU_Address = '0;
    bus.CPU_WData = '0;
    bus.OP_Request = 1'b0;
    bus.OPERATIONS = '0;
    model_reset();
    for (int v = 0; v < 32; v++) begin
      pfn = 20'h00200 + 20'($urandom_range(0, 255));
      mem[PTB + 32'(v * 4)] = {pfn, 11'd0, ($urandom_range(0, 4) != 0)};
    end
    for (int v = 8; v <= 12; v++) mem[PTB + 32'(v * 4)] = {20'h00300 + 20'(v), 12'h001};
    mem[32'h0010_000C] = 32'h0007_7001;
    mem[32'h0010_0014] = 32'h0000_0000;
    mem[32'h0007_7ABC] = 32'h1234_5678;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    // miss, walk, then access
    do_req(32'h0000_3ABC, 1'b0, 32'd0, 1'b0, 4'd0, lat);
    chk("t1_rdata", bus.CPU_RData, 32'h1234_5678);
    chk("t1_misses", 32'(misses), 32'd1);
    // hit with fixed latency
    do_req(32'h0000_3FF0, 1'b0, 32'd0, 1'b0, 4'd0, lat);
    chk("hit_latency", 32'(lat), 32'd3);
    chk("t2_hits", 32'(hits), 32'd1);
    // page fault on write
    do_req(32'h0000_5004, 1'b1, 32'd2, 1'b0, 4'd0, lat);
    chk("t3_misses", 32'(misses), 32'd2);
    do_req(32'h0000_3ABC, 1'b0, 32'd0, 1'b0, 4'd0, lat);
    chk("t3_tlb_kept_hits", 32'(hits), 32'd2);
    // flush and ignored opcode
    do_op(4'b1000);
    do_req(32'h0000_3ABC, 1'b0, 32'd0, 1'b0, 4'd0, lat);
    chk("flush_miss", 32'(misses), 32'd3);
    do_op(4'b1001);
    do_req(32'h0000_3ABC, 1'b0, 32'd0, 1'b0, 4'd0, lat);
    chk("noflush_hit", 32'(hits), 32'd3);
    // replacement: five pages into four entries
    do_op(4'b1000);
    for (int v = 8; v <= 12; v++) do_req({12'd0, 8'(v), 12'h010}, 1'b0, 32'd0, 1'b0, 4'd0, lat);
    chk("fill5_misses", 32'(misses), 32'd8);
    do_req({12'd0, 8'd9, 12'h020}, 1'b0, 32'd0, 1'b0, 4'd0, lat);
    chk("page1_hit", 32'(hits), 32'd4);
    do_req({12'd0, 8'd8, 12'h030}, 1'b0, 32'd0, 1'b0, 4'd0, lat);
    chk("page0_miss", 32'(misses), 32'd9);

    // random traffic, including flush simultaneous with a request
    for (int k = 0; k < 150; k++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 1) == 1) ? 4'b1000 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) do_op(op);
      do_req({16'd0, 4'($urandom_range(0, 15)), 12'($urandom_range(0, 4095))},
             ($urandom_range(0, 2) == 0), $urandom, ($urandom_range(0, 7) == 0), op, lat);
    end

    // reset while the physical access is outstanding
    do_op(4'b1000);
    do_req(32'h0000_3ABC, 1'b0, 32'd0, 1'b0, 4'd0, lat);
    model_req(32'h0000_3ABC, 1'b0, 32'd0, dummy);
    l1_hold = 1'b1;
    @(negedge clk);
    bus.CPU_Address = 32'h0000_3ABC;
    bus.CPU_WE = 1'b0;
    bus.CPU_Request = 1'b1;
    n = 0;
    while (!bus.VMEM_Request && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("acc_req_reached", 32'(bus.VMEM_Request), 32'd1);
    reset = 1'b1;
    bus.CPU_Request = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals("midreset");
    model_reset();
    l1_hold = 1'b0;
    @(negedge clk);
    do_req(32'h0000_3ABC, 1'b0, 32'd0, 1'b0, 4'd0, lat);
    chk("post_reset_misses", 32'(misses), 32'd1);
    chk("post_reset_hits", 32'(hits), 32'd0);

    repeat (4) @(negedge clk);
    chk("l1_queue_drained", 32'(l1_q.size()), 32'd0);
    chk("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
